pc_gen: RTL and testbench
=========================

# pc_gen

Registered program-counter generator for the NF5 front end; successor to the combinational next-PC select. Holds the fetch PC in a register, issues fetch requests to the Icache over a valid/ready handshake, applies branch/exception redirects by fixed priority, and buffers a redirect that arrives while a request is stalled in the handshake. Sits between Ctrl/EX/Decode (redirect and increment sources) and the Icache request port.

## Interface
- ADDR_WIDTH, 32, PC / target width
- START_PC, 32'h8000_0000, PC value loaded at reset
- PC_PLUS_WIDTH, 3, width of Decode increment code
- SEQ_BASE, 0, sequential base: 0 = IFID_NowPC, 1 = own Fetch_ReqPC
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- Ctrl_Stall  in  1  blocks issue of new requests
- Ctrl_ExcpFlag  in  1  exception redirect request
- Ctrl_ExcpPC  in  ADDR_WIDTH  exception target
- EX_BranchFlag  in  1  branch redirect request
- EX_BranchPC  in  ADDR_WIDTH  branch target
- Decode_NextPC  in  PC_PLUS_WIDTH  increment code (PC_PLUS_0/2/4/6/8)
- IFID_NowPC  in  ADDR_WIDTH  PC of instruction in IFID
- Icache_ReqReady  in  1  Icache accepts request this cycle
- Fetch_ReqValid  out  1  request valid
- Fetch_ReqPC  out  ADDR_WIDTH  request PC (the PC register)
- Fetch_RedirectPend  out  1  buffered redirect waiting
- Fetch_Flush  out  1  one-cycle pulse: PC was loaded from a redirect

## Operation
- Reset (rst_n=0 at edge): Fetch_ReqPC=START_PC, Fetch_ReqValid=0, Fetch_RedirectPend=0, pending target=0, Fetch_Flush=0.
- States: IDLE (ReqValid=0), REQ (ReqValid=1). Encoded in ReqValid itself.
- fire = Fetch_ReqValid & Icache_ReqReady.
- Redirect source priority: EX_BranchFlag > Ctrl_ExcpFlag > pending buffer > sequential.
- Sequential target = base + {0,2,4,6,8} per Decode_NextPC; unrecognised code -> base+2. Addition modulo 2^ADDR_WIDTH (wraps, no flag).
- IDLE: any live or pending redirect loads PC directly, clears pending, pulses Flush. No redirect: PC holds. Go REQ next cycle iff Ctrl_Stall=0.
- REQ, no fire: PC and ReqValid held stable (no withdrawal, Ctrl_Stall ignored). Live redirect written into pending buffer (branch wins if both; a newer redirect overwrites older pending).
- REQ, fire: PC <= highest-priority target (live redirect, else pending, else sequential); pending cleared; Flush pulses if target came from live or pending redirect. Next state REQ if Ctrl_Stall=0, else IDLE.
- Fetch_Flush is registered: asserted the cycle the new PC appears on Fetch_ReqPC.

## Timing
- Redirect-to-request latency: 1 cycle (redirect at edge N, new PC + Flush valid after edge N, request fires earliest at N+1).
- Redirect during unaccepted request: new PC appears 1 cycle after the accepting edge.
- First request: ReqValid rises 1 cycle after rst_n deasserts (if Ctrl_Stall=0).
- Reset mid-handshake: request dropped immediately, pending discarded.
- Outputs are pure register outputs; only combinational path is inputs -> next-state logic.

## Structure
- PC_PLUS_* codes, PC_PLUS_WIDTH, ADDR_WIDTH, START_PC defaults live in shared Define.v.
- One sub-module: pc_next_sel, combinational priority mux + sequential adder (inputs: flags, targets, pending, base, code; outputs: target, is_redirect).
- pc_gen holds PC, ReqValid, pending buffer, Flush registers.

## Test plan
- Reset release, Ready=1, code PC_PLUS_4 with SEQ_BASE=1: ReqPC sequence 8000_0000, 8000_0004, 8000_0008; Flush never asserts.
- Ready=0 for 3 cycles, EX_BranchFlag with 8000_1000 in cycle 2: ReqPC stays 8000_0004, RedirectPend=1; after fire ReqPC=8000_1000, Flush=1 one cycle, Pend=0.
- Same cycle EX_BranchFlag(8000_2000) and Ctrl_ExcpFlag(8000_0100), Ready=1: ReqPC=8000_2000.
- Ctrl_Stall=1 while ReqValid=1, Ready=0: ReqValid stays 1 until fire, then 0; exception in IDLE loads target, ReqValid returns when Stall drops.
- ReqPC=FFFF_FFFC, code PC_PLUS_8: next ReqPC=0000_0004; invalid code 3'b111: +2.
- rst_n=0 with pending redirect and ReqValid=1: next cycle ReqPC=START_PC, ReqValid=0, Pend=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared defaults, increment codes and the fetch FSM encoding for the NF5 PC generator.
package pc_gen_pkg;

  localparam int          ADDR_WIDTH_DEF    = 32;
  localparam logic [31:0] START_PC_DEF      = 32'h8000_0000;
  localparam int          PC_PLUS_WIDTH_DEF = 3;

  localparam logic [PC_PLUS_WIDTH_DEF-1:0] PC_PLUS_0 = 3'd0;
  localparam logic [PC_PLUS_WIDTH_DEF-1:0] PC_PLUS_2 = 3'd1;
  localparam logic [PC_PLUS_WIDTH_DEF-1:0] PC_PLUS_4 = 3'd2;
  localparam logic [PC_PLUS_WIDTH_DEF-1:0] PC_PLUS_6 = 3'd3;
  localparam logic [PC_PLUS_WIDTH_DEF-1:0] PC_PLUS_8 = 3'd4;

  // The state bit doubles as Fetch_ReqValid.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

  // Unknown codes fall back to a compressed-instruction step.
  function automatic logic [3:0] pc_plus_incr(input logic [PC_PLUS_WIDTH_DEF-1:0] code);
    case (code)
      PC_PLUS_0: pc_plus_incr = 4'd0;
      PC_PLUS_2: pc_plus_incr = 4'd2;
      PC_PLUS_4: pc_plus_incr = 4'd4;
      PC_PLUS_6: pc_plus_incr = 4'd6;
      PC_PLUS_8: pc_plus_incr = 4'd8;
      default:   pc_plus_incr = 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Icache fetch-request handshake between the PC generator and the Icache.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Fetch_ReqValid;
  logic [ADDR_WIDTH-1:0] Fetch_ReqPC;
  logic                  Icache_ReqReady;

  modport master (output Fetch_ReqValid, Fetch_ReqPC, input Icache_ReqReady);
  modport slave  (input Fetch_ReqValid, Fetch_ReqPC, output Icache_ReqReady);
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: branch > exception > pending redirect > sequential step.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int PC_PLUS_WIDTH = PC_PLUS_WIDTH_DEF
) (
  input  logic                     branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]    branch_pc_i,
  input  logic                     excp_flag_i,
  input  logic [ADDR_WIDTH-1:0]    excp_pc_i,
  input  logic                     pend_flag_i,
  input  logic [ADDR_WIDTH-1:0]    pend_pc_i,
  input  logic [ADDR_WIDTH-1:0]    base_i,
  input  logic [PC_PLUS_WIDTH-1:0] code_i,
  output logic [ADDR_WIDTH-1:0]    target_o,
  output logic                     is_redirect_o
);

  logic [ADDR_WIDTH-1:0] seq_pc;

  // Sequential step wraps modulo 2^ADDR_WIDTH.
  assign seq_pc = base_i + ADDR_WIDTH'(pc_plus_incr(PC_PLUS_WIDTH_DEF'(code_i)));

  always_comb begin
    target_o      = seq_pc;
    is_redirect_o = 1'b1;
    if (branch_flag_i) begin
      target_o = branch_pc_i;
    end else if (excp_flag_i) begin
      target_o = excp_pc_i;
    end else if (pend_flag_i) begin
      target_o = pend_pc_i;
    end else begin
      is_redirect_o = 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch-PC generator: issues Icache requests and buffers redirects
// that arrive while a request is stalled in the handshake.
//
// state  | meaning
// S_IDLE | no request outstanding; redirects load the PC directly
// S_REQ  | request presented; PC frozen until the Icache accepts it
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] START_PC      = ADDR_WIDTH'(START_PC_DEF),
  parameter int                    PC_PLUS_WIDTH = PC_PLUS_WIDTH_DEF,
  parameter int                    SEQ_BASE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Ctrl_Stall,
  input  logic                     Ctrl_ExcpFlag,
  input  logic [ADDR_WIDTH-1:0]    Ctrl_ExcpPC,
  input  logic                     EX_BranchFlag,
  input  logic [ADDR_WIDTH-1:0]    EX_BranchPC,
  input  logic [PC_PLUS_WIDTH-1:0] Decode_NextPC,
  input  logic [ADDR_WIDTH-1:0]    IFID_NowPC,
  pc_gen_if.master                 fetch_if,
  output logic                     Fetch_RedirectPend,
  output logic                     Fetch_Flush
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  flush_q, flush_d;

  logic                  fire;
  logic [ADDR_WIDTH-1:0] seq_base;
  logic [ADDR_WIDTH-1:0] sel_target;
  logic                  sel_redirect;

  assign fire     = (state_q == S_REQ) && fetch_if.Icache_ReqReady;
  assign seq_base = (SEQ_BASE != 0) ? pc_q : IFID_NowPC;

  pc_next_sel #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .PC_PLUS_WIDTH(PC_PLUS_WIDTH)
  ) u_next_sel (
    .branch_flag_i(EX_BranchFlag),
    .branch_pc_i  (EX_BranchPC),
    .excp_flag_i  (Ctrl_ExcpFlag),
    .excp_pc_i    (Ctrl_ExcpPC),
    .pend_flag_i  (pend_q),
    .pend_pc_i    (pend_pc_q),
    .base_i       (seq_base),
    .code_i       (Decode_NextPC),
    .target_o     (sel_target),
    .is_redirect_o(sel_redirect)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    flush_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_redirect) begin
          pc_d    = sel_target;
          pend_d  = 1'b0;
          flush_d = 1'b1;
        end
        state_d = Ctrl_Stall ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        if (fire) begin
          pc_d    = sel_target;
          pend_d  = 1'b0;
          flush_d = sel_redirect;
          state_d = Ctrl_Stall ? S_IDLE : S_REQ;
        end else if (EX_BranchFlag) begin
          // Request must stay stable; remember the newest redirect instead.
          pend_d    = 1'b1;
          pend_pc_d = EX_BranchPC;
        end else if (Ctrl_ExcpFlag) begin
          pend_d    = 1'b1;
          pend_pc_d = Ctrl_ExcpPC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      flush_q   <= flush_d;
    end
  end

  assign fetch_if.Fetch_ReqValid = (state_q == S_REQ);
  assign fetch_if.Fetch_ReqPC    = pc_q;
  assign Fetch_RedirectPend      = pend_q;
  assign Fetch_Flush             = flush_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table plus randomized traffic against a
// behavioural model, on one SEQ_BASE=1 and one SEQ_BASE=0 instance.
module tb_pc_gen;

  localparam logic [31:0] START = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, excp, br;
  logic [31:0] excp_pc, br_pc, ifid;
  logic [2:0]  code;
  logic        ready;

  logic        pend0, flush0, pend1, flush1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, index 0 = SEQ_BASE 1, index 1 = SEQ_BASE 0
  logic [31:0] m_pc[2];
  logic        m_v[2], m_p[2], m_f[2];
  logic [31:0] m_ppc[2];

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_WIDTH(32)) if0 ();
  pc_gen_if #(.ADDR_WIDTH(32)) if1 ();

  assign if0.Icache_ReqReady = ready;
  assign if1.Icache_ReqReady = ready;

  pc_gen #(.ADDR_WIDTH(32), .START_PC(START), .PC_PLUS_WIDTH(3), .SEQ_BASE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .Ctrl_Stall(stall), .Ctrl_ExcpFlag(excp), .Ctrl_ExcpPC(excp_pc),
    .EX_BranchFlag(br), .EX_BranchPC(br_pc), .Decode_NextPC(code), .IFID_NowPC(ifid),
    .fetch_if(if0), .Fetch_RedirectPend(pend0), .Fetch_Flush(flush0));

  pc_gen #(.ADDR_WIDTH(32), .START_PC(START), .PC_PLUS_WIDTH(3), .SEQ_BASE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .Ctrl_Stall(stall), .Ctrl_ExcpFlag(excp), .Ctrl_ExcpPC(excp_pc),
    .EX_BranchFlag(br), .EX_BranchPC(br_pc), .Decode_NextPC(code), .IFID_NowPC(ifid),
    .fetch_if(if1), .Fetch_RedirectPend(pend1), .Fetch_Flush(flush1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] step_of(input logic [2:0] c);
    int steps[5] = '{0, 2, 4, 6, 8};
    return (c < 3'd5) ? 32'(steps[c]) : 32'd2;
  endfunction

  // Advance one model by one clock edge using the pre-edge inputs.
  task automatic model_edge(input int k, input logic [31:0] base);
    logic        live;
    logic [31:0] live_pc;
    live    = br | excp;
    live_pc = br ? br_pc : excp_pc;
    if (!rst_n) begin
      m_pc[k] = START; m_v[k] = 0; m_p[k] = 0; m_ppc[k] = 0; m_f[k] = 0;
    end else if (!m_v[k]) begin
      m_f[k] = live | m_p[k];
      if (live) m_pc[k] = live_pc;
      else if (m_p[k]) m_pc[k] = m_ppc[k];
      m_p[k] = 0;
      m_v[k] = !stall;
    end else if (!ready) begin
      m_f[k] = 0;
      if (live) begin m_p[k] = 1; m_ppc[k] = live_pc; end
    end else begin
      m_f[k] = live | m_p[k];
      if (live) m_pc[k] = live_pc;
      else if (m_p[k]) m_pc[k] = m_ppc[k];
      else m_pc[k] = base + step_of(code);
      m_p[k] = 0;
      m_v[k] = !stall;
    end
  endtask

  task automatic tick();
    logic [31:0] base0, base1;
    base0 = m_pc[0];
    base1 = ifid;
    @(posedge clk);
    #1;
    model_edge(0, base0);
    model_edge(1, base1);
    chk("m0_pc",    if0.Fetch_ReqPC,          m_pc[0]);
    chk("m0_valid", 32'(if0.Fetch_ReqValid),  32'(m_v[0]));
    chk("m0_pend",  32'(pend0),               32'(m_p[0]));
    chk("m0_flush", 32'(flush0),              32'(m_f[0]));
    chk("m1_pc",    if1.Fetch_ReqPC,          m_pc[1]);
    chk("m1_valid", 32'(if1.Fetch_ReqValid),  32'(m_v[1]));
    chk("m1_pend",  32'(pend1),               32'(m_p[1]));
    chk("m1_flush", 32'(flush1),              32'(m_f[1]));
  endtask

  typedef struct {
    logic        rst_n, stall, excp;
    logic [31:0] excp_pc;
    logic        br;
    logic [31:0] br_pc;
    logic [2:0]  code;
    logic        ready;
    logic [31:0] e_pc;
    logic        e_v, e_p, e_f;
  } vec_t;

  vec_t tbl[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = START; m_v[k] = 0; m_p[k] = 0; m_ppc[k] = 0; m_f[k] = 0;
    end
    rst_n = 0; stall = 0; excp = 0; br = 0; excp_pc = 0; br_pc = 0;
    ifid = 0; code = 3'd2; ready = 0;

    //             rst stl exc exc_pc        br  br_pc         code  rdy   pc            v  p  f
    tbl.push_back('{0, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0000, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0000, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0004, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_0004, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         1, 32'h8000_1000, 3'd2, 0,   32'h8000_0004, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_0004, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_1000, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_1004, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 32'h8000_0100, 1, 32'h8000_2000, 3'd2, 1,   32'h8000_2000, 1, 0, 1});
    tbl.push_back('{1, 1, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_2000, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_2000, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_2004, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 32'h8000_0300, 0, 32'h0,         3'd2, 1,   32'h8000_0300, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0300, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0300, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd4, 1,   32'h8000_0308, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 3'd4, 1,   32'hFFFF_FFFC, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd4, 1,   32'h0000_0004, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd7, 1,   32'h0000_0006, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd0, 1,   32'h0000_0006, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd3, 1,   32'h0000_000C, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd1, 1,   32'h0000_000E, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         1, 32'h8000_5000, 3'd2, 0,   32'h0000_000E, 1, 1, 0});
    tbl.push_back('{1, 0, 1, 32'h8000_6000, 0, 32'h0,         3'd2, 0,   32'h0000_000E, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_6000, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 32'h0,         1, 32'h8000_7000, 3'd2, 0,   32'h8000_6000, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_0000, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 0,   32'h8000_0000, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,         0, 32'h0,         3'd2, 1,   32'h8000_0004, 1, 0, 0});

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; stall = tbl[i].stall; excp = tbl[i].excp; excp_pc = tbl[i].excp_pc;
      br = tbl[i].br; br_pc = tbl[i].br_pc; code = tbl[i].code; ready = tbl[i].ready;
      ifid = $urandom & 32'hFFFF_FFFE;
      tick();
      chk($sformatf("vec%0d_pc", i),    if0.Fetch_ReqPC,         tbl[i].e_pc);
      chk($sformatf("vec%0d_valid", i), 32'(if0.Fetch_ReqValid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_pend", i),  32'(pend0),              32'(tbl[i].e_p));
      chk($sformatf("vec%0d_flush", i), 32'(flush0),             32'(tbl[i].e_f));
    end

    // Randomized traffic; redirects sparse enough that sequential runs occur.
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 149) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      br      = ($urandom_range(0, 9) == 0);
      excp    = ($urandom_range(0, 9) == 0);
      br_pc   = $urandom & 32'hFFFF_FFFE;
      excp_pc = $urandom & 32'hFFFF_FFFE;
      ifid    = $urandom & 32'hFFFF_FFFE;
      code    = 3'($urandom_range(0, 7));
      ready   = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
